// File: rtl/bram_arbiter_if.sv
// ============================================================================
// Module      : bram_arbiter_if
// Description : Bus bundle between the fetch/LSU requesters, the arbiter and
//               the single-port combinational-read BRAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_arbiter_if;
    // Instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    // Load/store unit port
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    // BRAM port
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module      : bram_arbiter
// Description : Round-robin sharing of one combinational-read BRAM port
//               between instruction fetch and the LSU, with byte-lane store
//               steering, load extension and registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_arbiter #(
    parameter int MEM_WORDS = 2048
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    bram_arbiter_if.slave  bus
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    // Which port was granted most recently; the other one wins a conflict.
    typedef enum logic {PTR_FETCH = 1'b0, PTR_LSU = 1'b1} ptr_t;

    ptr_t        last_ptr;
    logic        fetch_gnt;
    logic        lsu_gnt;
    logic        fetch_bad;
    logic        lsu_bad;
    logic        lsu_store_ok;
    logic [1:0]  lsu_ofs;
    logic [3:0]  store_we;
    logic [31:0] store_data;
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    assign lsu_ofs = bus.lsu_addr[1:0];

    // Arbitration: single requester wins outright, conflicts alternate.
    always_comb begin
        fetch_gnt = 1'b0;
        lsu_gnt   = 1'b0;
        if (rst_n) begin
            if (bus.lsu_req && (!bus.if_req || last_ptr == PTR_FETCH)) begin
                lsu_gnt = 1'b1;
            end else if (bus.if_req) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    // Alignment and range checks for both requesters.
    always_comb begin
        fetch_bad = (bus.if_addr[1:0] != 2'b00) ||
                    ({2'b00, bus.if_addr[31:2]} >= MEM_WORDS_W);
        case (bus.lsu_size)
            2'b00:   lsu_bad = 1'b0;
            2'b01:   lsu_bad = bus.lsu_addr[0];
            2'b10:   lsu_bad = (bus.lsu_addr[1:0] != 2'b00);
            default: lsu_bad = 1'b1;
        endcase
        if ({2'b00, bus.lsu_addr[31:2]} >= MEM_WORDS_W) begin
            lsu_bad = 1'b1;
        end
    end

    // Store lane steering: strobes follow the byte offset, data is replicated
    // so whichever lanes are enabled already carry the right bytes.
    always_comb begin
        case (bus.lsu_size)
            2'b00: begin
                store_we   = 4'b0001 << lsu_ofs;
                store_data = {4{bus.lsu_wdata[7:0]}};
            end
            2'b01: begin
                store_we   = 4'b0011 << lsu_ofs;
                store_data = {2{bus.lsu_wdata[15:0]}};
            end
            default: begin
                store_we   = 4'b1111;
                store_data = bus.lsu_wdata;
            end
        endcase
    end

    // Memory port is driven directly by whichever request holds the grant.
    always_comb begin
        lsu_store_ok  = lsu_gnt && bus.lsu_we && !lsu_bad;
        bus.mem_addr  = lsu_gnt ? {bus.lsu_addr[31:2], 2'b00}
                                : {bus.if_addr[31:2], 2'b00};
        bus.mem_we    = lsu_store_ok ? store_we : 4'b0000;
        bus.mem_wdata = lsu_store_ok ? store_data : 32'h0;
    end

    // Load extraction: shift the addressed lane down, then extend.
    always_comb begin
        load_shifted = bus.mem_rdata >> {lsu_ofs, 3'b000};
        case (bus.lsu_size)
            2'b00:   load_data = {{24{!bus.lsu_unsigned && load_shifted[7]}},
                                  load_shifted[7:0]};
            2'b01:   load_data = {{16{!bus.lsu_unsigned && load_shifted[15]}},
                                  load_shifted[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    assign bus.if_gnt  = fetch_gnt;
    assign bus.lsu_gnt = lsu_gnt;

    // Response capture on the grant edge and last-grant pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rvalid  <= 1'b0;
            bus.if_rdata   <= 32'h0;
            bus.if_err     <= 1'b0;
            bus.lsu_rvalid <= 1'b0;
            bus.lsu_rdata  <= 32'h0;
            bus.lsu_err    <= 1'b0;
            last_ptr       <= PTR_FETCH;
        end else begin
            bus.if_rvalid  <= fetch_gnt;
            bus.lsu_rvalid <= lsu_gnt;
            if (fetch_gnt) begin
                bus.if_err   <= fetch_bad;
                bus.if_rdata <= fetch_bad ? 32'h0 : bus.mem_rdata;
            end
            if (lsu_gnt) begin
                bus.lsu_err   <= lsu_bad;
                bus.lsu_rdata <= (lsu_bad || bus.lsu_we) ? 32'h0 : load_data;
            end
            if (lsu_gnt) begin
                last_ptr <= PTR_LSU;
            end else if (fetch_gnt) begin
                last_ptr <= PTR_FETCH;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
// Module      : tb_bram_arbiter
// Description : Self-checking bench for bram_arbiter with a behavioural BRAM
//               and per-port response scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_arbiter;

    localparam int MEM_WORDS = 2048;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    resp_t if_q[$];
    resp_t lsu_q[$];

    logic [31:0] mem [0:MEM_WORDS-1];

    bram_arbiter_if bus ();

    bram_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural single-port BRAM: combinational read, byte-enabled write.
    assign bus.mem_rdata = mem[bus.mem_addr[12:2]];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_we[i]) mem[bus.mem_addr[12:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Response monitors: every rvalid must match the oldest expectation and
    // arrive exactly one cycle after its grant.
    always @(negedge clk) begin
        resp_t fe;
        resp_t le;
        if (bus.if_rvalid === 1'b1) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++;
                $display("FAIL if_resp: unexpected if_rvalid at cycle %0d", cycle);
            end else begin
                fe = if_q.pop_front();
                if (bus.if_rdata !== fe.rdata || bus.if_err !== fe.err || cycle != fe.cyc + 1) begin
                    errors++;
                    $display("FAIL if_resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             bus.if_rdata, bus.if_err, cycle, fe.rdata, fe.err, fe.cyc + 1);
                end
            end
        end
        if (bus.lsu_rvalid === 1'b1) begin
            checks++;
            if (lsu_q.size() == 0) begin
                errors++;
                $display("FAIL lsu_resp: unexpected lsu_rvalid at cycle %0d", cycle);
            end else begin
                le = lsu_q.pop_front();
                if (bus.lsu_rdata !== le.rdata || bus.lsu_err !== le.err || cycle != le.cyc + 1) begin
                    errors++;
                    $display("FAIL lsu_resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             bus.lsu_rdata, bus.lsu_err, cycle, le.rdata, le.err, le.cyc + 1);
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch_access(input logic [31:0] addr, input logic [31:0] exp_data,
                                input logic exp_err);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1 || bus.lsu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt @%h: if_gnt=%b lsu_gnt=%b, required 1/0", addr, bus.if_gnt, bus.lsu_gnt);
        end
        checks++;
        if (bus.mem_addr !== {addr[31:2], 2'b00} || bus.mem_we !== 4'b0000) begin
            errors++;
            $display("FAIL fetch_mem @%h: mem_addr=%h mem_we=%b, required %h/0000",
                     addr, bus.mem_addr, bus.mem_we, {addr[31:2], 2'b00});
        end
        if_q.push_back('{exp_data, exp_err, cycle});
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    task automatic lsu_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
        bus.lsu_req      = 1'b1;
        bus.lsu_we       = we;
        bus.lsu_size     = size;
        bus.lsu_unsigned = uns;
        bus.lsu_addr     = addr;
        bus.lsu_wdata    = wdata;
        @(negedge clk);
        checks++;
        if (bus.lsu_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lsu_gnt @%h: lsu_gnt=%b if_gnt=%b, required 1/0", addr, bus.lsu_gnt, bus.if_gnt);
        end
        checks++;
        if (bus.mem_addr !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL lsu_mem_addr @%h: got %h, required %h", addr, bus.mem_addr, {addr[31:2], 2'b00});
        end
        checks++;
        if (bus.mem_we !== exp_we) begin
            errors++;
            $display("FAIL lsu_mem_we @%h: got %b, required %b", addr, bus.mem_we, exp_we);
        end
        if (exp_we != 4'b0000) begin
            checks++;
            if (bus.mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL lsu_mem_wdata @%h: got %h, required %h", addr, bus.mem_wdata, exp_wdata);
            end
        end
        lsu_q.push_back('{exp_rdata, exp_err, cycle});
        @(posedge clk);
        #1;
        bus.lsu_req = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b1;
        bus.lsu_size = 2'b10;
        bus.lsu_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b0 || bus.lsu_gnt !== 1'b0 || bus.mem_we !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: if_gnt=%b lsu_gnt=%b mem_we=%b, required 0/0/0000",
                     bus.if_gnt, bus.lsu_gnt, bus.mem_we);
        end
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0 || bus.if_err !== 1'b0 ||
            bus.lsu_err !== 1'b0 || bus.if_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: if_rv=%b lsu_rv=%b if_err=%b lsu_err=%b if_rd=%h lsu_rd=%h, required all 0",
                     bus.if_rvalid, bus.lsu_rvalid, bus.if_err, bus.lsu_err, bus.if_rdata, bus.lsu_rdata);
        end
        bus.if_req  = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch;
        mem[4] <= 32'hDEADBEEF;
        mem[2] <= 32'h0BADF00D;
        fetch_access(32'h0000_0010, 32'hDEADBEEF, 1'b0);
        fetch_access(32'h0000_0008, 32'h0BADF00D, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back;
        // Fresh reset so the pointer starts at FETCH.
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        bus.if_req       = 1'b1;
        bus.if_addr      = 32'h0000_0010;
        bus.lsu_req      = 1'b1;
        bus.lsu_we       = 1'b0;
        bus.lsu_size     = 2'b10;
        bus.lsu_unsigned = 1'b0;
        bus.lsu_addr     = 32'h0000_0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.lsu_gnt !== ((k % 2) == 0) || bus.if_gnt !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL dual_gnt[%0d]: lsu_gnt=%b if_gnt=%b, required %b/%b",
                         k, bus.lsu_gnt, bus.if_gnt, (k % 2) == 0, (k % 2) == 1);
            end
            if ((k % 2) == 0) lsu_q.push_back('{32'hDEADBEEF, 1'b0, cycle});
            else              if_q.push_back('{32'hDEADBEEF, 1'b0, cycle});
            @(posedge clk);
            #1;
        end
        bus.if_req  = 1'b0;
        bus.lsu_req = 1'b0;
        idle(1);
    endtask

    task automatic test_store_byte;
        mem[1] <= 32'h11223344;
        idle(1);
        lsu_access(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00A5, 4'b0100, 32'hA5A5A5A5, 32'h0, 1'b0);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFA5, 1'b0);
        lsu_access(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 4'b0000, 32'h0, 32'h000000A5, 1'b0);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 4'b0000, 32'h0, 32'h00000033, 1'b0);
        checks++;
        if (mem[1] !== 32'h11A53344) begin
            errors++;
            $display("FAIL store_byte_mem: word1=%h, required 11a53344", mem[1]);
        end
        lsu_access(1'b1, 2'b00, 1'b0, 32'h3, 32'hFFFF_FF7F, 4'b1000, 32'h7F7F7F7F, 32'h0, 1'b0);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 4'b0000, 32'h0, 32'h0000007F, 1'b0);
        idle(1);
    endtask

    task automatic test_half_word;
        mem[0] <= 32'h80011234;
        idle(1);
        lsu_access(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
        lsu_access(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 4'b0000, 32'h0, 32'h00008001, 1'b0);
        lsu_access(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00001234, 1'b0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h0, 32'h1234_BEEF, 4'b0011, 32'hBEEFBEEF, 32'h0, 1'b0);
        lsu_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h8001BEEF, 1'b0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_5566, 4'b1100, 32'h55665566, 32'h0, 1'b0);
        lsu_access(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 4'b1111, 32'h12345678, 32'h0, 1'b0);
        fetch_access(32'h8, 32'h12345678, 1'b0);
        fetch_access(32'h0, 32'h5566BEEF, 1'b0);
        idle(1);
    endtask

    task automatic test_errors;
        logic [31:0] snap;
        mem[1] <= 32'hCAFEF00D;
        idle(1);
        snap = mem[1];
        lsu_access(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        lsu_access(1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        lsu_access(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h99999999, 4'b0000, 32'h0, 32'h0, 1'b1);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h99999999, 4'b0000, 32'h0, 32'h0, 1'b1);
        lsu_access(1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'h99999999, 4'b0000, 32'h0, 32'h0, 1'b1);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h0000_1FFF, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
        fetch_access(32'h0000_0006, 32'h0, 1'b1);
        fetch_access(32'h0000_2000, 32'h0, 1'b1);
        idle(1);
        checks++;
        if (mem[1] !== snap) begin
            errors++;
            $display("FAIL err_mem_unchanged: word1=%h, required %h", mem[1], snap);
        end
    endtask

    task automatic test_reset_pending;
        // Reset lands mid-cycle after a grant, before the capture edge.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_gnt: if_gnt=%b, required 1", bus.if_gnt);
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_drop: if_rvalid=%b if_gnt=%b, required 0/0", bus.if_rvalid, bus.if_gnt);
        end
        bus.if_req = 1'b0;
        rst_n = 1'b1;
        // Reset lands while a registered LSU response is on the outputs.
        lsu_access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
        rst_n = 1'b0;
        void'(lsu_q.pop_back());
        #1;
        checks++;
        if (bus.lsu_rvalid !== 1'b0 || bus.lsu_rdata !== 32'h0 || bus.lsu_err !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_clear: lsu_rvalid=%b lsu_rdata=%h lsu_err=%b, required 0/0/0",
                     bus.lsu_rvalid, bus.lsu_rdata, bus.lsu_err);
        end
        bus.if_req   = 1'b1;
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b1;
        bus.lsu_size = 2'b10;
        bus.lsu_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b0 || bus.lsu_gnt !== 1'b0 || bus.mem_we !== 4'b0000) begin
            errors++;
            $display("FAIL rstpend_hold: if_gnt=%b lsu_gnt=%b mem_we=%b, required 0/0/0000",
                     bus.if_gnt, bus.lsu_gnt, bus.mem_we);
        end
        @(posedge clk);
        #1;
        bus.lsu_we = 1'b0;
        rst_n = 1'b1;
        // Pointer must be back at FETCH: the first conflict goes to the LSU.
        @(negedge clk);
        checks++;
        if (bus.lsu_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_ptr: lsu_gnt=%b if_gnt=%b, required 1/0", bus.lsu_gnt, bus.if_gnt);
        end
        lsu_q.push_back('{32'hDEADBEEF, 1'b0, cycle});
        @(posedge clk);
        #1;
        bus.lsu_req = 1'b0;
        bus.if_req  = 1'b0;
        fetch_access(32'h0000_0010, 32'hDEADBEEF, 1'b0);
        idle(1);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.if_req       = 1'b0;
        bus.if_addr      = 32'h0;
        bus.lsu_req      = 1'b0;
        bus.lsu_we       = 1'b0;
        bus.lsu_size     = 2'b00;
        bus.lsu_unsigned = 1'b0;
        bus.lsu_addr     = 32'h0;
        bus.lsu_wdata    = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;

        test_reset();
        test_fetch();
        test_back_to_back();
        test_store_byte();
        test_half_word();
        test_errors();
        test_reset_pending();
        idle(3);

        checks++;
        if (if_q.size() != 0 || lsu_q.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: if_q=%0d lsu_q=%0d outstanding, required 0/0", if_q.size(), lsu_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
